// File: rtl/pc_unit.sv
// Program-counter unit: holds the architectural PC, picks the next PC from
// trap / mret / redirect / stall / sequential sources, and gates fetch through a BOOT/RUN/HALT FSM.
module pc_unit #(
  parameter int          XLEN         = 32,
  parameter logic [63:0] RESET_VECTOR = 64'h8000_0000,
  parameter int          IALIGN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            inc_half,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic [XLEN-1:0] trap_epc,
  input  logic            mret,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            fetch_valid,
  output logic [XLEN-1:0] epc,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr,
  output logic            halted
);

  localparam logic [XLEN-1:0] RST_PC    = RESET_VECTOR[XLEN-1:0];
  localparam logic [XLEN-1:0] TRAP_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] EPC_MASK  = (IALIGN == 16) ? {{(XLEN-1){1'b1}}, 1'b0}
                                                         : {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state;
  logic            half_step;
  logic            target_misaligned;
  logic [XLEN-1:0] next_pc;
  logic            take_misalign;

  assign half_step         = (IALIGN == 16) && inc_half;
  assign pc_plus           = pc + (half_step ? XLEN'(2) : XLEN'(4));
  assign target_misaligned = (IALIGN == 16) ? redirect_target[0] : (|redirect_target[1:0]);

  // Next-PC selection while running; a misaligned redirect holds pc and only flags it.
  always_comb begin
    next_pc       = pc;
    take_misalign = 1'b0;
    if (trap_valid) begin
      next_pc = trap_vector & TRAP_MASK;
    end else if (mret) begin
      next_pc = epc;
    end else if (redirect_valid) begin
      if (target_misaligned) begin
        take_misalign = 1'b1;
      end else begin
        next_pc = redirect_target;
      end
    end else if (!stall) begin
      next_pc = pc_plus;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RST_PC;
      epc           <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      halted        <= 1'b0;
      fetch_valid   <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          pc <= next_pc;
          if (trap_valid) begin
            epc <= trap_epc & EPC_MASK;
          end
          if (take_misalign) begin
            misalign      <= 1'b1;
            misalign_addr <= redirect_target;
          end
          // The PC update of the halting cycle still commits.
          if (halt_req) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end
        end
        HALT: begin
          if (trap_valid) begin
            pc  <= trap_vector & TRAP_MASK;
            epc <= trap_epc & EPC_MASK;
          end
          if (resume) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
            halted      <= 1'b0;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: one IALIGN=32 and one IALIGN=16 instance share stimulus.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall, inc_half, rv, tv, mret, hreq, resume;
  logic [31:0] rt, tvec, tepc;

  logic [31:0] pc32, pcp32, epc32, misa32;
  logic        fv32, mis32, h32;
  logic [31:0] pc16, pcp16, epc16, misa16;
  logic        fv16, mis16, h16;

  int errors = 0;
  int checks = 0;

  pc_unit #(.XLEN(32), .RESET_VECTOR(64'h8000_0000), .IALIGN(32)) d32 (
    .clk(clk), .rst(rst), .stall(stall), .inc_half(inc_half),
    .redirect_valid(rv), .redirect_target(rt), .trap_valid(tv), .trap_vector(tvec),
    .trap_epc(tepc), .mret(mret), .halt_req(hreq), .resume(resume),
    .pc(pc32), .pc_plus(pcp32), .fetch_valid(fv32), .epc(epc32),
    .misalign(mis32), .misalign_addr(misa32), .halted(h32)
  );

  pc_unit #(.XLEN(32), .RESET_VECTOR(64'h8000_0000), .IALIGN(16)) d16 (
    .clk(clk), .rst(rst), .stall(stall), .inc_half(inc_half),
    .redirect_valid(rv), .redirect_target(rt), .trap_valid(tv), .trap_vector(tvec),
    .trap_epc(tepc), .mret(mret), .halt_req(hreq), .resume(resume),
    .pc(pc16), .pc_plus(pcp16), .fetch_valid(fv16), .epc(epc16),
    .misalign(mis16), .misalign_addr(misa16), .halted(h16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    stall = 0; inc_half = 0; rv = 0; tv = 0; mret = 0; hreq = 0; resume = 0;
    rt = '0; tvec = '0; tepc = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc32 !== 32'h8000_0000) begin errors++; $display("[TB] FAIL reset_pc: got %h want %h", pc32, 32'h8000_0000); end
    checks++; if (fv32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_fv: got %b want 0", fv32); end
    checks++; if (epc32 !== 32'h0) begin errors++; $display("[TB] FAIL reset_epc: got %h want 0", epc32); end
    checks++; if (misa32 !== 32'h0) begin errors++; $display("[TB] FAIL reset_misaddr: got %h want 0", misa32); end
    checks++; if (mis32 !== 1'b0 || h32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got mis=%b halt=%b want 0 0", mis32, h32); end
    // Release reset; a misaligned redirect offered in BOOT must be ignored.
    rst = 0; rv = 1; rt = 32'h8000_0102;
    checks++; if (pc32 !== 32'h8000_0000 || fv32 !== 1'b0) begin errors++; $display("[TB] FAIL boot_cycle1: got pc=%h fv=%b want 80000000 0", pc32, fv32); end
    tick();
    checks++; if (fv32 !== 1'b1) begin errors++; $display("[TB] FAIL boot_cycle2_fv: got %b want 1", fv32); end
    checks++; if (pc32 !== 32'h8000_0000 || pc16 !== 32'h8000_0000) begin errors++; $display("[TB] FAIL boot_cycle2_pc: got %h/%h want 80000000", pc32, pc16); end
    checks++; if (mis32 !== 1'b0) begin errors++; $display("[TB] FAIL boot_no_misalign: got %b want 0", mis32); end
    clear_inputs();
    tick();
    checks++; if (pc32 !== 32'h8000_0004 || pc16 !== 32'h8000_0004) begin errors++; $display("[TB] FAIL boot_cycle3_pc: got %h/%h want 80000004", pc32, pc16); end
  endtask

  task automatic test_redirect_stall();
    rv = 1; rt = 32'h8000_0010;
    tick();
    checks++; if (pc32 !== 32'h8000_0010) begin errors++; $display("[TB] FAIL redirect_basic: got %h want 80000010", pc32); end
    rv = 1; rt = 32'h8000_0100; stall = 1;
    tick();
    checks++; if (pc32 !== 32'h8000_0100 || pc16 !== 32'h8000_0100) begin errors++; $display("[TB] FAIL redirect_over_stall: got %h/%h want 80000100", pc32, pc16); end
    rv = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc32 !== 32'h8000_0100) begin errors++; $display("[TB] FAIL stall_hold%0d: got %h want 80000100", i, pc32); end
    end
    clear_inputs();
  endtask

  task automatic test_misalign();
    rv = 1; rt = 32'h8000_0102;
    tick();
    checks++; if (pc32 !== 32'h8000_0100) begin errors++; $display("[TB] FAIL misalign_pc_hold: got %h want 80000100", pc32); end
    checks++; if (mis32 !== 1'b1) begin errors++; $display("[TB] FAIL misalign_pulse: got %b want 1", mis32); end
    checks++; if (misa32 !== 32'h8000_0102) begin errors++; $display("[TB] FAIL misalign_addr: got %h want 80000102", misa32); end
    checks++; if (pc16 !== 32'h8000_0102 || mis16 !== 1'b0) begin errors++; $display("[TB] FAIL half_redirect: got pc=%h mis=%b want 80000102 0", pc16, mis16); end
    clear_inputs();
    inc_half = 1;
    #1;
    checks++; if (pcp16 !== 32'h8000_0104) begin errors++; $display("[TB] FAIL half_pc_plus: got %h want 80000104", pcp16); end
    checks++; if (pcp32 !== 32'h8000_0104) begin errors++; $display("[TB] FAIL full_ignores_half: got %h want 80000104", pcp32); end
    tick();
    checks++; if (mis32 !== 1'b0) begin errors++; $display("[TB] FAIL misalign_one_cycle: got %b want 0", mis32); end
    checks++; if (misa32 !== 32'h8000_0102) begin errors++; $display("[TB] FAIL misalign_addr_held: got %h want 80000102", misa32); end
    checks++; if (pc16 !== 32'h8000_0104 || pc32 !== 32'h8000_0104) begin errors++; $display("[TB] FAIL after_half_step: got %h/%h want 80000104", pc16, pc32); end
    clear_inputs();
  endtask

  task automatic test_trap_priority();
    tv = 1; tvec = 32'h0000_0203; tepc = 32'h8000_0040;
    mret = 1; rv = 1; rt = 32'h8000_0300;
    tick();
    checks++; if (pc32 !== 32'h0000_0200 || pc16 !== 32'h0000_0200) begin errors++; $display("[TB] FAIL trap_pc: got %h/%h want 00000200", pc32, pc16); end
    checks++; if (epc32 !== 32'h8000_0040) begin errors++; $display("[TB] FAIL trap_epc: got %h want 80000040", epc32); end
    clear_inputs();
    tick();
    checks++; if (pc32 !== 32'h0000_0204) begin errors++; $display("[TB] FAIL after_trap_seq: got %h want 00000204", pc32); end
    mret = 1;
    tick();
    checks++; if (pc32 !== 32'h8000_0040 || pc16 !== 32'h8000_0040) begin errors++; $display("[TB] FAIL mret_pc: got %h/%h want 80000040", pc32, pc16); end
    clear_inputs();
    tv = 1; tvec = 32'h0000_0300; tepc = 32'h8000_0046;
    tick();
    checks++; if (epc32 !== 32'h8000_0044) begin errors++; $display("[TB] FAIL epc_mask32: got %h want 80000044", epc32); end
    checks++; if (epc16 !== 32'h8000_0046) begin errors++; $display("[TB] FAIL epc_mask16: got %h want 80000046", epc16); end
    clear_inputs();
  endtask

  task automatic test_halt();
    hreq = 1;
    tick();
    checks++; if (pc32 !== 32'h0000_0304) begin errors++; $display("[TB] FAIL halt_commit_pc: got %h want 00000304", pc32); end
    checks++; if (h32 !== 1'b1 || fv32 !== 1'b0) begin errors++; $display("[TB] FAIL halt_enter: got halted=%b fv=%b want 1 0", h32, fv32); end
    clear_inputs();
    rv = 1; rt = 32'h0000_0500;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pc32 !== 32'h0000_0304 || fv32 !== 1'b0) begin errors++; $display("[TB] FAIL halt_frozen%0d: got pc=%h fv=%b want 00000304 0", i, pc32, fv32); end
    end
    clear_inputs();
    tv = 1; tvec = 32'h0000_0400; tepc = 32'h8000_0080;
    tick();
    checks++; if (pc32 !== 32'h0000_0400 || epc32 !== 32'h8000_0080) begin errors++; $display("[TB] FAIL halt_trap: got pc=%h epc=%h want 00000400 80000080", pc32, epc32); end
    checks++; if (h32 !== 1'b1) begin errors++; $display("[TB] FAIL halt_trap_stays: got %b want 1", h32); end
    clear_inputs();
    hreq = 1; resume = 1;
    tick();
    checks++; if (h32 !== 1'b0 || fv32 !== 1'b1 || pc32 !== 32'h0000_0400) begin errors++; $display("[TB] FAIL resume_wins: got halted=%b fv=%b pc=%h want 0 1 00000400", h32, fv32, pc32); end
    clear_inputs();
    tick();
    checks++; if (pc32 !== 32'h0000_0404) begin errors++; $display("[TB] FAIL resume_seq: got %h want 00000404", pc32); end
    hreq = 1;
    tick();
    checks++; if (h32 !== 1'b1 || pc32 !== 32'h0000_0408) begin errors++; $display("[TB] FAIL halt_again: got halted=%b pc=%h want 1 00000408", h32, pc32); end
    clear_inputs();
    // Asynchronous reset while halted, checked before any clock edge.
    #2 rst = 1;
    #1;
    checks++; if (pc32 !== 32'h8000_0000 || h32 !== 1'b0 || fv32 !== 1'b0 || epc32 !== 32'h0) begin errors++; $display("[TB] FAIL async_reset: got pc=%h halted=%b fv=%b epc=%h want 80000000 0 0 0", pc32, h32, fv32, epc32); end
    rst = 0;
    tick();
    checks++; if (fv32 !== 1'b1 || pc32 !== 32'h8000_0000) begin errors++; $display("[TB] FAIL reboot: got fv=%b pc=%h want 1 80000000", fv32, pc32); end
  endtask

  task automatic test_wrap();
    rv = 1; rt = 32'hFFFF_FFFC;
    tick();
    checks++; if (pc32 !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_setup: got %h want fffffffc", pc32); end
    clear_inputs();
    #1;
    checks++; if (pcp32 !== 32'h0000_0000) begin errors++; $display("[TB] FAIL wrap_pc_plus: got %h want 00000000", pcp32); end
    tick();
    checks++; if (pc32 !== 32'h0000_0000 || mis32 !== 1'b0 || fv32 !== 1'b1) begin errors++; $display("[TB] FAIL wrap_pc: got pc=%h mis=%b fv=%b want 00000000 0 1", pc32, mis32, fv32); end
    tick();
    checks++; if (pc32 !== 32'h0000_0004) begin errors++; $display("[TB] FAIL wrap_continue: got %h want 00000004", pc32); end
  endtask

  initial begin
    $display("[TB] pc_unit directed bench starting");
    test_reset();
    test_redirect_stall();
    test_misalign();
    test_trap_priority();
    test_halt();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle RISC-V core and its pipelined successors.
- Holds the architectural PC and selects the next PC from four sources: sequential increment (4 or 2 bytes), branch/jump redirect, trap entry and MRET return.
- Adds stall, an internal exception-PC register, misaligned-target detection, and a boot/halt state machine that gates fetch validity.
- Sits between the fetch stage and the branch/CSR logic.

Parameters:
XLEN, 32, PC and address width in bits (32 or 64).
RESET_VECTOR, 32'h8000_0000 (zero-extended to XLEN), PC value loaded on reset.
IALIGN, 32, instruction alignment in bits: 32 requires 4-byte targets; 16 allows 2-byte targets and compressed increment.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hold PC, no advance.
inc_half  in  1  current instruction is compressed, increment by 2. Ignored when IALIGN=32.
redirect_valid  in  1  taken branch/jump this cycle.
redirect_target  in  XLEN  branch/jump target.
trap_valid  in  1  take trap this cycle.
trap_vector  in  XLEN  trap handler address (low 2 bits forced to 0).
trap_epc  in  XLEN  PC of the faulting instruction, captured into epc.
mret  in  1  return from trap to epc.
halt_req  in  1  enter HALT (debug/WFI).
resume  in  1  leave HALT.
pc  out  XLEN  current PC.
pc_plus  out  XLEN  pc + 4, or pc + 2 when inc_half && IALIGN=16 (combinational).
fetch_valid  out  1  pc is a valid fetch address this cycle.
epc  out  XLEN  exception PC register.
misalign  out  1  one-cycle pulse: redirect target was misaligned.
misalign_addr  out  XLEN  offending target, held until next misalign.
halted  out  1  FSM in HALT.

Behaviour:
- Reset (rst=1, asynchronous):
  - pc=RESET_VECTOR, epc=0, misalign=0, misalign_addr=0, halted=0, fetch_valid=0.
  - FSM=BOOT.
  - A reset asserted mid-operation overrides everything immediately.
- FSM states: BOOT, RUN, HALT.
  - BOOT: fetch_valid=0, pc held. Always goes to RUN on the next edge. First valid fetch is therefore at RESET_VECTOR, 1 cycle after rst deassertion.
  - RUN: fetch_valid=1. halt_req=1 goes to HALT at the edge, but the selected PC update for that cycle still commits.
  - HALT: fetch_valid=0, halted=1, pc frozen. Still accepts trap_valid (pc/epc update, stays HALT). resume=1 goes to RUN. halt_req and resume both high in HALT: resume wins.
- Next-PC priority in RUN, highest first: trap_valid > mret > redirect_valid > stall > sequential.
  - trap: pc<=trap_vector with [1:0] cleared; epc<=trap_epc with [0] cleared (and [1] cleared when IALIGN=32).
  - mret: pc<=epc.
  - redirect:
    - Aligned target (IALIGN=32: target[1:0]==0; IALIGN=16: target[0]==0): pc<=target.
    - Misaligned target: pc held, misalign=1 for exactly 1 cycle, misalign_addr<=target. Downstream CSR logic raises the trap.
  - stall: pc held. A simultaneous redirect/trap/mret still wins over stall.
  - sequential: pc<=pc_plus.
- Width rules:
  - All adds are modulo 2^XLEN. pc=0xFFFF_FFFC with sequential advance wraps to 0x0000_0000 with no flag.
  - pc[0] is always 0. pc[1] is always 0 when IALIGN=32.
- trap and mret in the same cycle: the trap wins, and epc takes the new trap_epc.
- Inputs in BOOT are ignored. misalign is never asserted outside RUN.
- Latency: every selection is visible on pc one edge after the inputs are sampled.

Test Plan:
1. XLEN=32: assert rst, release at cycle 0, no other inputs -> pc=0x8000_0000 with fetch_valid=0 in cycle 1; fetch_valid=1 in cycle 2; pc=0x8000_0004 in cycle 3.
2. RUN at pc=0x8000_0010: redirect_valid=1 with target 0x8000_0100 and stall=1 -> pc=0x8000_0100 next cycle. Then stall=1 alone for 3 cycles -> pc holds 0x8000_0100.
3. IALIGN=32, target 0x8000_0102 -> pc unchanged, misalign=1 for 1 cycle, misalign_addr=0x8000_0102. Same target with IALIGN=16 -> pc=0x8000_0102; then inc_half=1 -> pc=0x8000_0104.
4. trap_valid with trap_vector=0x0000_0203, trap_epc=0x8000_0040, plus mret and redirect in the same cycle -> pc=0x0000_0200, epc=0x8000_0040. Later mret alone -> pc=0x8000_0040.
5. halt_req in RUN -> halted=1, fetch_valid=0, pc frozen over 5 cycles. Then resume -> fetch_valid=1 and sequential advance continues. rst pulsed while halted -> pc=0x8000_0000, state BOOT.
6. pc=0xFFFF_FFFC sequential -> pc=0x0000_0000 next cycle, no flags.
